// File: rtl/life_gen_sequencer.sv
// Row-by-row Game-of-Life generation sequencer over a double-banked cell memory.
// Optional handshake watchdog enabled by defining LIFE_SEQ_TIMEOUT_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for step or run_en
// WAIT  | free-run pacing, DELAY cycles (at least one) before READ
// READ  | three neighbour-row reads: (r-1), r, (r+1) with toroidal wrap
// CALC  | engine started; waiting for eng_done
// WRITE | result row written into the shadow bank
// SWAP  | bank toggle, gen_count increment, gen_done pulse
module life_gen_sequencer #(
  parameter int ROWS    = 16,
  parameter int ROW_AW  = 4,
  parameter int DELAY   = 16,
  parameter int GEN_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_en,
  input  logic              step,
  output logic              rd_req,
  output logic [ROW_AW-1:0] rd_row,
  output logic [1:0]        rd_sel,
  input  logic              rd_ack,
  output logic              eng_start,
  input  logic              eng_done,
  output logic              wr_req,
  output logic [ROW_AW-1:0] wr_row,
  input  logic              wr_ack,
  output logic              bank,
  output logic              busy,
  output logic              gen_done,
  output logic [GEN_W-1:0]  gen_count,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_SWAP  = 3'd5;

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);

  // WAIT lasts max(DELAY,1) cycles: load DELAY-1 and leave on terminal count.
  localparam int DLY_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = (DELAY > 0) ? DLY_W'(DELAY - 1) : '0;

  logic [2:0]        state;
  logic [ROW_AW-1:0] row;
  logic [DLY_W-1:0]  dly_cnt;
  logic [ROW_AW-1:0] row_prev;
  logic [ROW_AW-1:0] row_next;
  logic              done_ok;
  logic              wd_expire;

  assign row_prev = (row == '0) ? LAST_ROW : row - 1'b1;
  assign row_next = (row == LAST_ROW) ? '0 : row + 1'b1;

  // eng_done is ignored in the cycle eng_start is high.
  assign done_ok = (state == S_CALC) && !eng_start && eng_done;

`ifdef LIFE_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic            wait_cyc;
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign wait_cyc = ((state == S_READ)  && !rd_ack) ||
                    ((state == S_CALC)  && !done_ok) ||
                    ((state == S_WRITE) && !wr_ack);
  assign wd_expire = wait_cyc && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign err = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (wd_expire)
        err_q <= 1'b1;
      if (wait_cyc && !wd_expire)
        wd_cnt <= wd_cnt + 1'b1;
      else
        wd_cnt <= '0;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      row       <= '0;
      dly_cnt   <= '0;
      rd_req    <= 1'b0;
      rd_row    <= '0;
      rd_sel    <= 2'd0;
      eng_start <= 1'b0;
      wr_req    <= 1'b0;
      wr_row    <= '0;
      bank      <= 1'b0;
      busy      <= 1'b0;
      gen_done  <= 1'b0;
      gen_count <= '0;
    end else begin
      gen_done <= 1'b0;
      if (wd_expire) begin
        state     <= S_IDLE;
        row       <= '0;
        rd_req    <= 1'b0;
        eng_start <= 1'b0;
        wr_req    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!err) begin
              if (step) begin
                state  <= S_READ;
                row    <= '0;
                rd_req <= 1'b1;
                rd_row <= LAST_ROW;
                rd_sel <= 2'd0;
                busy   <= 1'b1;
              end else if (run_en) begin
                state   <= S_WAIT;
                dly_cnt <= DLY_LOAD;
              end
            end
          end
          S_WAIT: begin
            if (!run_en) begin
              state <= S_IDLE;
            end else if (dly_cnt == '0) begin
              state  <= S_READ;
              row    <= '0;
              rd_req <= 1'b1;
              rd_row <= LAST_ROW;
              rd_sel <= 2'd0;
              busy   <= 1'b1;
            end else begin
              dly_cnt <= dly_cnt - 1'b1;
            end
          end
          S_READ: begin
            if (rd_ack) begin
              case (rd_sel)
                2'd0: begin
                  rd_sel <= 2'd1;
                  rd_row <= row;
                end
                2'd1: begin
                  rd_sel <= 2'd2;
                  rd_row <= row_next;
                end
                default: begin
                  rd_req    <= 1'b0;
                  eng_start <= 1'b1;
                  state     <= S_CALC;
                end
              endcase
            end
          end
          S_CALC: begin
            eng_start <= 1'b0;
            if (done_ok) begin
              state  <= S_WRITE;
              wr_req <= 1'b1;
              wr_row <= row;
            end
          end
          S_WRITE: begin
            if (wr_ack) begin
              wr_req <= 1'b0;
              if (row == LAST_ROW) begin
                state     <= S_SWAP;
                bank      <= ~bank;
                gen_count <= gen_count + 1'b1;
                gen_done  <= 1'b1;
              end else begin
                // The new row's r-1 neighbour is the row just written.
                state  <= S_READ;
                row    <= row_next;
                rd_req <= 1'b1;
                rd_row <= row;
                rd_sel <= 2'd0;
              end
            end
          end
          S_SWAP: begin
            busy <= 1'b0;
            row  <= '0;
            if (run_en) begin
              state   <= S_WAIT;
              dly_cnt <= DLY_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  logic unused_prev;
  assign unused_prev = ^row_prev;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Directed bench for life_gen_sequencer with ROWS=4, DELAY=2; acks high and
// eng_done returned one cycle after eng_start unless a test overrides them.
module tb_life_gen_sequencer;
  localparam int ROWS = 4;
  localparam int ROW_AW = 2;
  localparam int DELAY = 2;
  localparam int GEN_W = 16;
  localparam int TIMEOUT = 64;

  logic              clk;
  logic              reset;
  logic              run_en;
  logic              step;
  logic              rd_req;
  logic [ROW_AW-1:0] rd_row;
  logic [1:0]        rd_sel;
  logic              rd_ack;
  logic              eng_start;
  logic              eng_done;
  logic              wr_req;
  logic [ROW_AW-1:0] wr_row;
  logic              wr_ack;
  logic              bank;
  logic              busy;
  logic              gen_done;
  logic [GEN_W-1:0]  gen_count;
  logic              err;

  int asserts = 0;
  int failures = 0;
  logic done_auto;
  logic last_start;

  life_gen_sequencer #(
    .ROWS(ROWS), .ROW_AW(ROW_AW), .DELAY(DELAY), .GEN_W(GEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .run_en(run_en), .step(step),
    .rd_req(rd_req), .rd_row(rd_row), .rd_sel(rd_sel), .rd_ack(rd_ack),
    .eng_start(eng_start), .eng_done(eng_done),
    .wr_req(wr_req), .wr_row(wr_row), .wr_ack(wr_ack),
    .bank(bank), .busy(busy), .gen_done(gen_done), .gen_count(gen_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: eng_done high for one cycle, the cycle after eng_start.
  initial begin
    last_start = 1'b0;
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      eng_done = done_auto && last_start;
      last_start = eng_start;
    end
  end

  task automatic apply_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #3;
    asserts++; if (rd_req !== 1'b0) begin failures++; $display("FAIL reset_rd_req got %b want 0", rd_req); end
    asserts++; if (rd_row !== '0) begin failures++; $display("FAIL reset_rd_row got %0d want 0", rd_row); end
    asserts++; if (rd_sel !== 2'd0) begin failures++; $display("FAIL reset_rd_sel got %0d want 0", rd_sel); end
    asserts++; if (eng_start !== 1'b0) begin failures++; $display("FAIL reset_eng_start got %b want 0", eng_start); end
    asserts++; if (wr_req !== 1'b0) begin failures++; $display("FAIL reset_wr_req got %b want 0", wr_req); end
    asserts++; if (wr_row !== '0) begin failures++; $display("FAIL reset_wr_row got %0d want 0", wr_row); end
    asserts++; if (bank !== 1'b0) begin failures++; $display("FAIL reset_bank got %b want 0", bank); end
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    asserts++; if (gen_done !== 1'b0) begin failures++; $display("FAIL reset_gen_done got %b want 0", gen_done); end
    asserts++; if (gen_count !== '0) begin failures++; $display("FAIL reset_gen_count got %0d want 0", gen_count); end
    asserts++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", err); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_step_generation;
    int exp_rd[12] = '{3, 0, 1, 0, 1, 2, 1, 2, 3, 2, 3, 0};
    int exp_wr[4] = '{0, 1, 2, 3};
    int rd_rows[$];
    int rd_sels[$];
    int wr_rows[$];
    int done_idx = -1;
    int starts = 0;
    int multi = 0;
    logic busy_at_done = 1'b0;
    int a;
    int s;
    @(negedge clk);
    step = 1'b1;
    for (int i = 0; i < 40 && done_idx < 0; i++) begin
      @(negedge clk);
      step = 1'b0;
      if (rd_req) begin rd_rows.push_back(int'(rd_row)); rd_sels.push_back(int'(rd_sel)); end
      if (wr_req) wr_rows.push_back(int'(wr_row));
      if (eng_start) starts++;
      if ((int'(rd_req) + int'(eng_start) + int'(wr_req)) > 1) multi++;
      if (gen_done) begin done_idx = i; busy_at_done = busy; end
    end
    asserts++; if (done_idx != 24) begin failures++; $display("FAIL step_gen_latency got %0d want 24", done_idx); end
    asserts++; if (rd_rows.size() != 12) begin failures++; $display("FAIL step_read_count got %0d want 12", rd_rows.size()); end
    for (int i = 0; i < 12; i++) begin
      a = (i < rd_rows.size()) ? rd_rows[i] : -1;
      s = (i < rd_sels.size()) ? rd_sels[i] : -1;
      asserts++; if (a != exp_rd[i] || s != i % 3) begin
        failures++; $display("FAIL step_read_%0d got (%0d,%0d) want (%0d,%0d)", i, a, s, exp_rd[i], i % 3);
      end
    end
    for (int i = 0; i < 4; i++) begin
      a = (i < wr_rows.size()) ? wr_rows[i] : -1;
      asserts++; if (a != exp_wr[i]) begin failures++; $display("FAIL step_write_%0d got %0d want %0d", i, a, exp_wr[i]); end
    end
    asserts++; if (starts != 4) begin failures++; $display("FAIL step_eng_starts got %0d want 4", starts); end
    asserts++; if (multi != 0) begin failures++; $display("FAIL step_exclusive_req got %0d want 0", multi); end
    asserts++; if (busy_at_done !== 1'b1) begin failures++; $display("FAIL step_busy_in_swap got %b want 1", busy_at_done); end
    @(negedge clk);
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL step_busy_after got %b want 0", busy); end
    asserts++; if (bank !== 1'b1) begin failures++; $display("FAIL step_bank got %b want 1", bank); end
    asserts++; if (gen_count !== 16'd1) begin failures++; $display("FAIL step_gen_count got %0d want 1", gen_count); end
    asserts++; if (gen_done !== 1'b0) begin failures++; $display("FAIL step_gen_done_pulse got %b want 0", gen_done); end
  endtask

  task automatic test_free_run;
    int ndone = 0;
    int gap = 0;
    int in_gap = 0;
    int gaps[$];
    int rd_after = 0;
    int g;
    apply_reset();
    run_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (gen_done) begin
        ndone++;
        in_gap = (ndone < 3) ? 1 : 0;
        gap = 0;
      end else if (in_gap != 0) begin
        if (rd_req) begin
          gaps.push_back(gap);
          in_gap = 0;
          if (ndone == 2) run_en = 1'b0;
        end else begin
          gap++;
        end
      end else if (ndone == 3 && rd_req) begin
        rd_after++;
      end
    end
    run_en = 1'b0;
    asserts++; if (ndone != 3) begin failures++; $display("FAIL run_gen_done_pulses got %0d want 3", ndone); end
    for (int i = 0; i < 2; i++) begin
      g = (i < gaps.size()) ? gaps[i] : -1;
      asserts++; if (g != 2) begin failures++; $display("FAIL run_wait_cycles_%0d got %0d want 2", i, g); end
    end
    asserts++; if (gen_count !== 16'd3) begin failures++; $display("FAIL run_gen_count got %0d want 3", gen_count); end
    asserts++; if (bank !== 1'b1) begin failures++; $display("FAIL run_bank got %b want 1", bank); end
    asserts++; if (rd_after != 0) begin failures++; $display("FAIL run_reads_after_stop got %0d want 0", rd_after); end
  endtask

  task automatic test_read_stall;
    int found = 0;
    int unstable = 0;
    int starts = 0;
    int seen = 0;
    apply_reset();
    step = 1'b1;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      step = 1'b0;
      if (rd_req && rd_row == 2'd0 && rd_sel == 2'd1) found = 1;
    end
    asserts++; if (found != 1) begin failures++; $display("FAIL stall_find_read got %0d want 1", found); end
    rd_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rd_req !== 1'b1 || rd_row !== 2'd0 || rd_sel !== 2'd1) unstable++;
      if (eng_start) starts++;
    end
    rd_ack = 1'b1;
    asserts++; if (unstable != 0) begin failures++; $display("FAIL stall_req_stable got %0d unstable cycles want 0", unstable); end
    asserts++; if (starts != 0) begin failures++; $display("FAIL stall_no_eng_start got %0d want 0", starts); end
    @(negedge clk);
    asserts++; if (rd_req !== 1'b1 || rd_row !== 2'd1 || rd_sel !== 2'd2) begin
      failures++; $display("FAIL stall_resume got req=%b (%0d,%0d) want req=1 (1,2)", rd_req, rd_row, rd_sel);
    end
    @(negedge clk);
    asserts++; if (eng_start !== 1'b1) begin failures++; $display("FAIL stall_eng_start got %b want 1", eng_start); end
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      if (gen_done) seen = 1;
    end
    asserts++; if (seen != 1) begin failures++; $display("FAIL stall_gen_done got %0d want 1", seen); end
    asserts++; if (gen_count !== 16'd1) begin failures++; $display("FAIL stall_gen_count got %0d want 1", gen_count); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int writes = 0;
    int found = 0;
    int activity = 0;
    @(negedge clk);
    step = 1'b1;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge clk);
      step = 1'b0;
      if (wr_req) writes++;
      if (eng_start && writes == 2) found = 1;
    end
    asserts++; if (found != 1) begin failures++; $display("FAIL rstmid_reach_row2_calc got %0d want 1", found); end
    reset = 1'b0;
    #1;
    asserts++; if ({rd_req, eng_start, wr_req, busy, gen_done} !== 5'b0) begin
      failures++; $display("FAIL rstmid_controls got %b want 00000", {rd_req, eng_start, wr_req, busy, gen_done});
    end
    asserts++; if ({rd_row, rd_sel, wr_row} !== '0) begin
      failures++; $display("FAIL rstmid_addresses got %b want 0", {rd_row, rd_sel, wr_row});
    end
    asserts++; if (bank !== 1'b0) begin failures++; $display("FAIL rstmid_bank got %b want 0", bank); end
    asserts++; if (gen_count !== '0) begin failures++; $display("FAIL rstmid_gen_count got %0d want 0", gen_count); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_req || busy) activity++;
    end
    asserts++; if (activity != 0) begin failures++; $display("FAIL rstmid_stays_idle got %0d active cycles want 0", activity); end
  endtask

  task automatic test_step_busy_drop;
    int busy_cyc = 0;
    int ndone = 0;
    int rd_after = 0;
    int starts = 0;
    run_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      step = 1'b0;
      if (busy) busy_cyc++;
      if (busy_cyc == 5 && busy) step = 1'b1;
      if (busy_cyc == 10 && busy) run_en = 1'b0;
      if (eng_start) starts++;
      if (gen_done) ndone++;
      else if (ndone > 0 && rd_req) rd_after++;
    end
    step = 1'b0;
    asserts++; if (ndone != 1) begin failures++; $display("FAIL drop_gen_done_pulses got %0d want 1", ndone); end
    asserts++; if (gen_count !== 16'd1) begin failures++; $display("FAIL drop_gen_count got %0d want 1", gen_count); end
    asserts++; if (starts != 4) begin failures++; $display("FAIL drop_eng_starts got %0d want 4", starts); end
    asserts++; if (rd_after != 0) begin failures++; $display("FAIL drop_reads_after got %0d want 0", rd_after); end
    asserts++; if (busy !== 1'b0 || bank !== 1'b1) begin
      failures++; $display("FAIL drop_final got busy=%b bank=%b want busy=0 bank=1", busy, bank);
    end
  endtask

  task automatic test_wait_abort;
    int reads = 0;
    @(negedge clk);
    run_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    run_en = 1'b0;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rd_req || busy) reads++;
    end
    asserts++; if (reads != 0) begin failures++; $display("FAIL wait_abort_activity got %0d want 0", reads); end
    asserts++; if (gen_count !== 16'd1) begin failures++; $display("FAIL wait_abort_gen_count got %0d want 1", gen_count); end
  endtask

`ifdef LIFE_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int n = 0;
    int seen = 0;
    int reads = 0;
    apply_reset();
    done_auto = 1'b0;
    step = 1'b1;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge clk);
      step = 1'b0;
      if (err) seen = 1;
      else if (eng_start || n > 0) n++;
    end
    asserts++; if (seen != 1) begin failures++; $display("FAIL timeout_err got %0d want 1", seen); end
    asserts++; if (n != 64) begin failures++; $display("FAIL timeout_calc_cycles got %0d want 64", n); end
    asserts++; if (busy !== 1'b0 || eng_start !== 1'b0 || rd_req !== 1'b0) begin
      failures++; $display("FAIL timeout_outputs got busy=%b start=%b rd=%b want 0 0 0", busy, eng_start, rd_req);
    end
    asserts++; if (gen_count !== '0 || bank !== 1'b0) begin
      failures++; $display("FAIL timeout_state got gen=%0d bank=%b want 0 0", gen_count, bank);
    end
    done_auto = 1'b1;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_req || busy) reads++;
    end
    asserts++; if (reads != 0 || err !== 1'b1) begin
      failures++; $display("FAIL timeout_step_ignored got reads=%0d err=%b want 0 1", reads, err);
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    run_en = 1'b0;
    step = 1'b0;
    rd_ack = 1'b1;
    wr_ack = 1'b1;
    done_auto = 1'b1;
    test_reset();
    test_step_generation();
    test_free_run();
    test_read_stall();
    test_reset_mid();
    test_step_busy_drop();
    test_wait_abort();
`ifdef LIFE_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
